hram_frame_writer: RTL
======================

# hram_frame_writer

Upstream request generator for `hyperram_ctrl`. Buffers the 16-bit Boson pixel stream in a tagged FIFO and issues linear write bursts on the controller's `sram_*` interface at an auto-incrementing word address. It also services single read-back requests (up to 8 words) from the SD/readout path. Writes take priority over reads.

## Interface
- `BASE_ADDR`, default 12'h000: word address loaded at start of frame.
- `BURST_LEN`, default 16: words per full write burst, 1..30.
- `FIFO_DEPTH`, default 64: pixel FIFO entries; power of 2, at least 2*BURST_LEN.
- `GAP_CYCLES`, default 8: `clk` cycles of idle forced after every burst, so the controller can reach idle.
- `RD_TIMEOUT`, default 255: maximum `clk` cycles to wait for all read words.
- `clk` in 1: system clock; same clock as `hyperram_ctrl.clk`.
- `reset_` in 1: asynchronous, active-low reset.
- `pix_valid` in 1: pixel strobe. There is no backpressure.
- `pix_sof` in 1: qualifies `pix_valid`; this pixel is the first of a frame.
- `pix_data` in 16: pixel word.
- `flush` in 1: level. While high, partial bursts are allowed.
- `rd_start` in 1: one-cycle read request; ignored while `rd_busy`.
- `rd_addr` in 12: read word address, sampled on `rd_start`.
- `rd_len` in 4: words to read, 1..8. A value of 0 is treated as 1; values above 8 are clamped to 8.
- `rd_out_vld` out 1: read word strobe.
- `rd_out_data` out 16: read word.
- `rd_busy` out 1: a read is pending or active.
- `rd_err` out 1: one-cycle pulse on read timeout.
- `overflow` out 1: sticky; a pixel was dropped. Cleared by the next accepted `pix_sof`.
- `fifo_level` out 7: current FIFO occupancy, width clog2(FIFO_DEPTH)+1.
- `sram_req` out 1: write burst active; to controller.
- `sram_ready` in 1: one-cycle pulse; the current `sram_wr_data` was consumed.
- `sram_rd` out 1: read burst active.
- `sram_addr` out 12: burst start address; stable while `sram_req` or `sram_rd` is high.
- `sram_wr_data` out 16: FIFO head word.
- `sram_rd_data_vld` in 1: read word strobe from the controller.
- `sram_rd_data` in 16: read word from the controller.

## Operation
- FIFO entries are 17 bits: {sof, data}.
  - Push when `pix_valid` is high and the FIFO is not full.
  - When `pix_valid` is high and the FIFO is full, drop the pixel and set `overflow`. A dropped pixel with `pix_sof` does not clear `overflow`.
  - A push and a pop in the same cycle leave `fifo_level` unchanged.
- Write address register `wr_addr` (12 bit) wraps modulo 4096.
- States:
  - **IDLE**: in priority order:
    - Start a write if `fifo_level` >= BURST_LEN, or if `flush` is high and `fifo_level` > 0. On start, `sram_addr` = BASE_ADDR if the head entry's sof tag is set, else `wr_addr`. Go to WR.
    - Else, if a read is pending, go to RD.
  - **WR**: `sram_req` = 1 and `sram_wr_data` = FIFO head.
    - Each `sram_ready` pops one entry and increments the word counter.
    - The burst ends after BURST_LEN pops, or when the FIFO empties.
    - The burst also ends when the next head entry carries a sof tag (mid-burst sof). That entry is not popped.
    - `sram_req` drops in the cycle after the terminating pop.
    - On exit, `wr_addr` = burst start + words popped. Go to GAP.
  - **RD**:
    - `sram_rd` = 1, `sram_addr` = latched `rd_addr`.
    - Each `sram_rd_data_vld` decrements the remaining count. When the count reaches 0, drop `sram_rd` the next cycle and go to GAP.
    - If RD_TIMEOUT cycles pass without completion, drop `sram_rd`, pulse `rd_err`, and go to GAP.
  - **GAP**: count GAP_CYCLES, then go to IDLE.
- Read path:
  - `rd_start` while not busy latches the request and sets `rd_busy`.
  - `rd_busy` clears on the cycle leaving RD.
  - `rd_out_vld`/`rd_out_data` are `sram_rd_data_vld`/`sram_rd_data` registered once, forwarded only in RD.
  - Extra `sram_rd_data_vld` pulses after the count reaches 0 are discarded.
- Async reset returns all state to IDLE and empties the FIFO. Reset values:
  - `wr_addr` = BASE_ADDR.
  - All outputs 0, including `overflow`.
  - `sram_wr_data` = 0.
  - `sram_addr` = 0.

## Timing
- `sram_req` or `sram_rd` rises 1 cycle after the IDLE start condition is true.
- Pop and next head:
  - A pop on `sram_ready` in cycle N presents the next head on `sram_wr_data` in cycle N+1.
  - Back-to-back `sram_ready` pulses are legal, one word per cycle.
- `sram_addr` changes only in IDLE.
- `rd_out_vld` trails `sram_rd_data_vld` by exactly 1 cycle.
- `rd_start` coinciding with a write start: the write wins and the read stays pending.
- Minimum spacing between bursts is GAP_CYCLES+1 cycles.

## Test plan
- **Single full burst:** reset, then push 16 pixels with sof on the first; model `sram_ready` every 4 cycles. Expect: `sram_addr` = 0x000, 16 words in order, `sram_req` low after the 16th pop, `wr_addr` = 0x010, `fifo_level` = 0.
- **Overflow:** hold `sram_ready` low and push 70 pixels. Expect: `fifo_level` = 64, `overflow` = 1, 6 pixels dropped. Then send a sof pixel after space frees. Expect: `overflow` = 0.
- **Flush and mid-burst sof:** push 5 words, then sof+3 words, then raise `flush`. Expect: burst 1 of 5 words at `wr_addr`, GAP, then burst 2 of 4 words at 0x000.
- **Read-back:** `rd_start`, `rd_addr` = 0x020, `rd_len` = 3; model returns 3 vld pulses. Expect: 3 `rd_out_vld` each 1 cycle late, `sram_rd` low after the 3rd, `rd_busy` cleared.
- **Read timeout:** `rd_len` = 8, model returns 2 words. Expect: `rd_err` pulse 255 cycles after entering RD, state back to IDLE after GAP.
- **Reset mid-burst and wrap-around:** `reset_` low during WR. Expect: `sram_req` = 0 immediately and FIFO empty. Also, burst start at `wr_addr` = 0xFF8 with 16 words. Expect: `wr_addr` = 0x008 afterwards.

Source files
------------

// File: rtl/hram_frame_writer.sv
// Pixel FIFO plus burst sequencer feeding hyperram_ctrl: linear write bursts from
// the Boson stream, with short read-back bursts served whenever no write is due.
module hram_frame_writer #(
  parameter logic [11:0] BASE_ADDR  = 12'h000,
  parameter int          BURST_LEN  = 16,
  parameter int          FIFO_DEPTH = 64,
  parameter int          GAP_CYCLES = 8,
  parameter int          RD_TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          reset_,
  input  logic                          pix_valid,
  input  logic                          pix_sof,
  input  logic [15:0]                   pix_data,
  input  logic                          flush,
  input  logic                          rd_start,
  input  logic [11:0]                   rd_addr,
  input  logic [3:0]                    rd_len,
  output logic                          rd_out_vld,
  output logic [15:0]                   rd_out_data,
  output logic                          rd_busy,
  output logic                          rd_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          sram_req,
  input  logic                          sram_ready,
  output logic                          sram_rd,
  output logic [11:0]                   sram_addr,
  output logic [15:0]                   sram_wr_data,
  input  logic                          sram_rd_data_vld,
  input  logic [15:0]                   sram_rd_data
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int WW = $clog2(BURST_LEN + 1);
  localparam int TW = $clog2(RD_TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, WR, RD, GAP} state_t;

  state_t        state, state_nxt;
  logic [16:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr, rptr_nxt;
  logic [LW-1:0] level;
  logic [16:0]   head;
  logic          full, push, pop, next_sof, burst_last, wr_go;
  logic [WW-1:0] wcnt;
  logic [TW-1:0] tmr;
  logic [GW-1:0] gcnt;
  logic [11:0]   wr_addr, rd_addr_q;
  logic [3:0]    rd_left, rd_len_c;
  logic          rd_done, rd_tmo;

  assign fifo_level = level;
  assign full       = (level == LW'(FIFO_DEPTH));
  assign push       = pix_valid && !full;
  assign pop        = (state == WR) && sram_ready && (level != '0);
  assign rptr_nxt   = rptr + 1'b1;
  assign head       = mem[rptr];
  assign wr_go      = (level >= LW'(BURST_LEN)) || (flush && (level != '0));

  // The entry that becomes head after this pop: a sof there ends the burst early.
  always_comb begin
    next_sof = 1'b0;
    if (level >= LW'(2))
      next_sof = mem[rptr_nxt][16];
    else if (push)
      next_sof = pix_sof;
  end

  assign burst_last = (wcnt == WW'(BURST_LEN - 1)) || ((level == LW'(1)) && !push) || next_sof;
  assign rd_done    = (state == RD) && sram_rd_data_vld && (rd_left == 4'd1);
  assign rd_tmo     = (state == RD) && (tmr == TW'(RD_TIMEOUT - 1)) && !rd_done;

  always_comb begin
    if (rd_len == 4'd0)
      rd_len_c = 4'd1;
    else if (rd_len > 4'd8)
      rd_len_c = 4'd8;
    else
      rd_len_c = rd_len;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wptr] <= {pix_sof, pix_data};
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr_nxt;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (pix_valid && full)
        overflow <= 1'b1;
      else if (push && pix_sof)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (wr_go)
          state_nxt = WR;
        else if (rd_busy)
          state_nxt = RD;
      end
      WR:      if (pop && burst_last) state_nxt = GAP;
      RD:      if (rd_done || rd_tmo) state_nxt = GAP;
      GAP:     if (gcnt == GW'(GAP_CYCLES - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sram_req     = (state == WR);
    sram_rd      = (state == RD);
    sram_wr_data = (state == WR) ? head[15:0] : 16'h0000;
  end

  // wr_addr is loaded with the burst start and then tracks each pop, so on exit
  // it already holds start + words written.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_addr     <= BASE_ADDR;
      sram_addr   <= 12'h000;
      wcnt        <= '0;
      tmr         <= '0;
      gcnt        <= '0;
      rd_busy     <= 1'b0;
      rd_addr_q   <= 12'h000;
      rd_left     <= 4'd0;
      rd_err      <= 1'b0;
      rd_out_vld  <= 1'b0;
      rd_out_data <= 16'h0000;
    end else begin
      rd_err     <= 1'b0;
      rd_out_vld <= 1'b0;
      case (state)
        IDLE: begin
          wcnt <= '0;
          tmr  <= '0;
          gcnt <= '0;
          if (wr_go) begin
            sram_addr <= head[16] ? BASE_ADDR : wr_addr;
            wr_addr   <= head[16] ? BASE_ADDR : wr_addr;
          end else if (rd_busy) begin
            sram_addr <= rd_addr_q;
          end
        end
        WR: begin
          if (pop) begin
            wcnt    <= wcnt + 1'b1;
            wr_addr <= wr_addr + 12'd1;
          end
        end
        RD: begin
          tmr <= tmr + 1'b1;
          if (sram_rd_data_vld && (rd_left != 4'd0)) begin
            rd_left     <= rd_left - 4'd1;
            rd_out_vld  <= 1'b1;
            rd_out_data <= sram_rd_data;
          end
          if (rd_tmo)
            rd_err <= 1'b1;
        end
        GAP:     gcnt <= gcnt + 1'b1;
        default: gcnt <= '0;
      endcase
      if ((state == RD) && (state_nxt != RD)) begin
        rd_busy <= 1'b0;
      end else if (rd_start && !rd_busy) begin
        rd_busy   <= 1'b1;
        rd_addr_q <= rd_addr;
        rd_left   <= rd_len_c;
      end
    end
  end

endmodule
